// File: rtl/btn_move_conditioner.sv
// ---------------------------------------------------------------------------
// btn_move_conditioner
//
// Purpose:
//   Turns the raw board pushbuttons into clean game commands for the 2048
//   game logic. Each button goes through a 2-flop synchronizer and then a
//   debouncer. The four direction buttons are priority-encoded (U>D>L>R)
//   into one move command. That command is held on a valid/ready handshake
//   until the game logic accepts it. The center button produces a one-cycle
//   soft-reset pulse.
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable cycles needed to accept a level
//                     change (minimum 2).
//   REPEAT_CYCLES   : hold time before an auto-repeat move (auto-repeat
//                     builds only).
//   CNT_W           : width of the debounce and repeat counters.
//
// Optional feature:
//   Define BTN_AUTOREPEAT_EN to re-issue the last move while its single
//   direction button stays held. The default build has no repeat counter
//   and issues exactly one move per press.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   btn_raw    in   raw buttons, asynchronous: [4]=C [3]=U [2]=D [1]=L [0]=R
//   move_ready in   game logic accepts the pending move this cycle
//   move_valid out  a move command is pending
//   move_dir   out  0=up 1=down 2=left 3=right, meaningful while move_valid
//   soft_rst   out  one-cycle pulse after a debounced C press
//   btn_level  out  debounced button levels, same bit order as btn_raw
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module btn_move_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 30000000,
  parameter int CNT_W           = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn_raw,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic       soft_rst,
  output logic [4:0] btn_level
);

  localparam int               C_BIT   = 4;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject configurations the counters cannot represent.
  if (DEBOUNCE_CYCLES < 2 ||
      CNT_W < $clog2(DEBOUNCE_CYCLES + 1) ||
      CNT_W < $clog2(REPEAT_CYCLES + 1)) begin : g_param_check
    $error("btn_move_conditioner: bad DEBOUNCE_CYCLES/REPEAT_CYCLES/CNT_W");
  end

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    WAIT_RELEASE
  } state_t;

  state_t           state;
  logic [4:0]       sync_q1;
  logic [4:0]       sync_q2;
  logic [CNT_W-1:0] db_cnt [5];
  logic [4:0]       btn_level_d;
  logic [4:0]       press;
  logic [1:0]       press_dir;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rpt_cnt;

  // One-hot btn_level[3:0] pattern of a single held direction.
  function automatic logic [3:0] dir_mask(input logic [1:0] d);
    return 4'b1000 >> d;
  endfunction
`endif

  // Two-stage synchronizer; sync_q2 is the metastability-safe copy.
  // NOTE: non-blocking assignments make each stage sample the previous
  // stage's old value, so this really is a two-flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Debounce: a level change is accepted only after DEBOUNCE_CYCLES
  // consecutive cycles of disagreement; any agreement restarts the count.
  // NOTE: the counter array is control state, not storage, so every element
  // gets an explicit reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_level <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync_q2[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          btn_level[i] <= ~btn_level[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_level_d <= '0;
    else        btn_level_d <= btn_level;
  end

  // Rising edges of the debounced levels, and the winning direction.
  // NOTE: press_dir gets its default before the if-chain, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    press     = btn_level & ~btn_level_d;
    press_dir = 2'd3;
    if      (press[3]) press_dir = 2'd0;
    else if (press[2]) press_dir = 2'd1;
    else if (press[1]) press_dir = 2'd2;
  end

  // Move FSM. A C press overrides everything: any pending move is dropped
  // (or counts as taken if it handshakes in the same cycle) and a direction
  // press arriving in that cycle is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      move_valid <= 1'b0;
      move_dir   <= 2'd0;
      soft_rst   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rpt_cnt    <= '0;
`endif
    end else begin
      soft_rst <= press[C_BIT];
`ifdef BTN_AUTOREPEAT_EN
      rpt_cnt  <= '0;
`endif
      if (press[C_BIT]) begin
        state      <= WAIT_RELEASE;
        move_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (|press[3:0]) begin
              state      <= HOLD;
              move_valid <= 1'b1;
              move_dir   <= press_dir;
            end
          end
          HOLD: begin
            if (move_valid && move_ready) begin
              state      <= WAIT_RELEASE;
              move_valid <= 1'b0;
            end
          end
          WAIT_RELEASE: begin
            if (btn_level[3:0] == 4'd0) begin
              state <= IDLE;
            end
`ifdef BTN_AUTOREPEAT_EN
            else if (btn_level[3:0] == dir_mask(move_dir)) begin
              if (rpt_cnt == RPT_LAST) begin
                state      <= HOLD;
                move_valid <= 1'b1;
              end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
              end
            end
`endif
          end
          default: begin
            state      <= IDLE;
            move_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_btn_move_conditioner.sv
// ---------------------------------------------------------------------------
// tb_btn_move_conditioner
//
// Self-checking bench for btn_move_conditioner with DEBOUNCE_CYCLES=4 and
// REPEAT_CYCLES=10. It runs directed sequences with hand-derived
// expectations, a table of single-press vectors, and a randomized phase.
// Every clock cycle is also compared against a behavioural model. In that
// model, a level flips once the last DEBOUNCE_CYCLES synchronized samples
// all disagree with it. Moves are tracked as pending / blocked-until-release
// flags.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_btn_move_conditioner;

  localparam int DB = 4;
  localparam int RP = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] btn_raw;
  logic       move_ready;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       soft_rst;
  logic [4:0] btn_level;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  btn_move_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_CYCLES  (RP),
    .CNT_W          (25)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .move_ready(move_ready),
    .move_valid(move_valid),
    .move_dir  (move_dir),
    .soft_rst  (soft_rst),
    .btn_level (btn_level)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [4:0] pipe0, pipe1;
  logic [4:0] win[$];
  logic [4:0] m_lvl, m_lvl_d;
  logic       m_pending, m_blocked, m_soft;
  logic [1:0] m_dir;
`ifdef BTN_AUTOREPEAT_EN
  int         m_held;
`endif

  function automatic logic [1:0] first_dir(input logic [3:0] p);
    for (int k = 3; k >= 0; k--) if (p[k]) return 2'(3 - k);
    return 2'd0;
  endfunction

  task automatic model_reset();
    pipe0 = '0; pipe1 = '0; win.delete();
    m_lvl = '0; m_lvl_d = '0;
    m_pending = 1'b0; m_blocked = 1'b0; m_soft = 1'b0; m_dir = 2'd0;
`ifdef BTN_AUTOREPEAT_EN
    m_held = 0;
`endif
  endtask

  task automatic model_step();
    logic [4:0] p;
    p = m_lvl & ~m_lvl_d;
    m_soft = p[4];
    if (p[4]) begin
      m_pending = 1'b0;
      m_blocked = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
      m_held = 0;
`endif
    end else if (m_pending) begin
      if (move_ready) begin
        m_pending = 1'b0;
        m_blocked = 1'b1;
      end
    end else if (m_blocked) begin
      if (m_lvl[3:0] == 4'd0) begin
        m_blocked = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        m_held = 0;
`endif
      end
`ifdef BTN_AUTOREPEAT_EN
      else if (m_lvl[3:0] == (4'b1000 >> m_dir)) begin
        m_held++;
        if (m_held == RP) begin
          m_pending = 1'b1;
          m_blocked = 1'b0;
          m_held    = 0;
        end
      end else begin
        m_held = 0;
      end
`endif
    end else if (|p[3:0]) begin
      m_pending = 1'b1;
      m_dir     = first_dir(p[3:0]);
    end
    // Debounce over a sliding window of synchronized samples.
    win.push_back(pipe1);
    if (win.size() > DB) void'(win.pop_front());
    m_lvl_d = m_lvl;
    if (win.size() == DB) begin
      for (int i = 0; i < 5; i++) begin
        bit all_diff;
        all_diff = 1'b1;
        foreach (win[k]) if (win[k][i] == m_lvl[i]) all_diff = 1'b0;
        if (all_diff) m_lvl[i] = ~m_lvl[i];
      end
    end
    pipe1 = pipe0;
    pipe0 = btn_raw;
  endtask

  // One clock: the model steps on the rising edge, and DUT and model are
  // compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("m_level", 8'(btn_level), 8'(m_lvl));
    check("m_valid", 8'(move_valid), 8'(m_pending));
    check("m_soft", 8'(soft_rst), 8'(m_soft));
    if (m_pending) check("m_dir", 8'(move_dir), 8'(m_dir));
  endtask

  task automatic release_all();
    move_ready = 1'b0;
    btn_raw    = '0;
    repeat (10) tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0] raw;
    logic       ready;
    logic [1:0] exp_dir;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{5'b01000, 1'b0, 2'd0};
    vecs[1] = '{5'b00100, 1'b0, 2'd1};
    vecs[2] = '{5'b00010, 1'b0, 2'd2};
    vecs[3] = '{5'b00001, 1'b0, 2'd3};
    vecs[4] = '{5'b01001, 1'b1, 2'd0};
    vecs[5] = '{5'b00110, 1'b1, 2'd1};
    vecs[6] = '{5'b00011, 1'b0, 2'd2};
    vecs[7] = '{5'b01111, 1'b1, 2'd0};

    rst_n = 1'b1; btn_raw = '0; move_ready = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_valid", 8'(move_valid), 8'd0);
    check("rst_dir", 8'(move_dir), 8'd0);
    check("rst_soft", 8'(soft_rst), 8'd0);
    check("rst_level", 8'(btn_level), 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // U held from reset release: move appears exactly 7 edges later.
    btn_raw = 5'b01000;
    repeat (6) tick();
    check("u_lat_early", 8'(move_valid), 8'd0);
    tick();
    check("u_lat_valid", 8'(move_valid), 8'd1);
    check("u_lat_dir", 8'(move_dir), 8'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("u_hold_valid", 8'(move_valid), 8'd1);
      check("u_hold_dir", 8'(move_dir), 8'd0);
    end
    move_ready = 1'b1;
    tick();
    check("u_hs_drop", 8'(move_valid), 8'd0);
    release_all();

    // L glitch of 3 cycles never reaches btn_level.
    btn_raw = 5'b00010;
    repeat (3) tick();
    btn_raw = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("glitch_level", 8'(btn_level[1]), 8'd0);
      check("glitch_valid", 8'(move_valid), 8'd0);
    end

    // Table of single presses with priority encoding.
    foreach (vecs[v]) begin
      btn_raw    = vecs[v].raw;
      move_ready = vecs[v].ready;
      repeat (7) tick();
      check("vec_valid", 8'(move_valid), 8'd1);
      check("vec_dir", 8'(move_dir), 8'(vecs[v].exp_dir));
      check("vec_level", 8'(btn_level), 8'(vecs[v].raw));
      if (!vecs[v].ready) begin
        repeat (3) tick();
        check("vec_held", 8'(move_valid), 8'd1);
        move_ready = 1'b1;
      end
      tick();
      check("vec_done", 8'(move_valid), 8'd0);
      release_all();
    end

    // U+R together with ready high: one single-cycle move, nothing more
    // until every direction is released.
    btn_raw = 5'b01001; move_ready = 1'b1;
    repeat (7) tick();
    check("ur_valid", 8'(move_valid), 8'd1);
    check("ur_dir", 8'(move_dir), 8'd0);
    tick();
    check("ur_one_cycle", 8'(move_valid), 8'd0);
    btn_raw = 5'b00001;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("ur_no_repress", 8'(move_valid), 8'd0);
    end
    btn_raw = '0;
    repeat (10) tick();
    btn_raw = 5'b01000;
    repeat (7) tick();
    check("ur_again_valid", 8'(move_valid), 8'd1);
    check("ur_again_dir", 8'(move_dir), 8'd0);
    tick();
    release_all();

    // Pending move cancelled by C press with ready held low.
    btn_raw = 5'b01000;
    repeat (7) tick();
    check("c_pending", 8'(move_valid), 8'd1);
    btn_raw = 5'b11000;
    repeat (6) tick();
    check("c_pre_soft", 8'(soft_rst), 8'd0);
    check("c_pre_valid", 8'(move_valid), 8'd1);
    tick();
    check("c_soft", 8'(soft_rst), 8'd1);
    check("c_drop", 8'(move_valid), 8'd0);
    tick();
    check("c_soft_end", 8'(soft_rst), 8'd0);
    check("c_stay_low", 8'(move_valid), 8'd0);
    release_all();

    // Async reset in HOLD with D still held.
    btn_raw = 5'b00100;
    repeat (7) tick();
    check("d_pending", 8'(move_dir), 8'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("ar_valid", 8'(move_valid), 8'd0);
    check("ar_level", 8'(btn_level), 8'd0);
    check("ar_dir", 8'(move_dir), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) tick();
    check("ar_early", 8'(move_valid), 8'd0);
    tick();
    check("ar_valid2", 8'(move_valid), 8'd1);
    check("ar_dir2", 8'(move_dir), 8'd1);
    move_ready = 1'b1;
    tick();
    release_all();

    // R held 40 cycles with ready high: auto-repeat spacing or one move.
    begin
      int cnt, last, first;
      cnt = 0; last = -1; first = -1;
      btn_raw = 5'b00001; move_ready = 1'b1;
      for (int i = 1; i <= 40; i++) begin
        tick();
        if (move_valid) begin
          if (last >= 0) check("rep_spacing", 8'(i - last), 8'd11);
          if (first < 0) first = i;
          last = i;
          cnt++;
        end
      end
      check("rep_first", 8'(first), 8'd7);
`ifdef BTN_AUTOREPEAT_EN
      check("rep_count", 8'(cnt), 8'd4);
`else
      check("rep_count", 8'(cnt), 8'd1);
`endif
      release_all();
    end

    // Randomized patterns of varied length against the model.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] pat;
      int hold;
      pat = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) != 0) pat[4] = 1'b0;
      hold = $urandom_range(1, 12);
      btn_raw = pat;
      for (int h = 0; h < hold; h++) begin
        move_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end
    release_all();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
